// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// scan state encodings, the all-segments-off code and default sizing.
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  localparam logic [6:0]  SEG_OFF          = 7'h7F;
  localparam int unsigned DEF_NUM_DIGITS   = 8;
  localparam int unsigned DEF_BLANK_CYCLES = 4;
  localparam int unsigned BCNT_W           = 8;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bundle of the scan controller's data/strobe inputs and display outputs.
// The master side feeds digits and the refresh tick; the slave side is the
// controller driving anodes, segments, decimal point and frame marker.
interface seg_scan_ctrl_if
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS
) ();

  logic                    tick;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_en;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   anode;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_done;

  modport master (
    output tick, digits, dp_en, blank,
    input  anode, seg, dp, frame_done
  );

  modport slave (
    input  tick, digits, dp_en, blank,
    output anode, seg, dp, frame_done
  );

endinterface

// File: rtl/hex_to_7seg.sv
// Purely combinational hex nibble to active-low {g,f,e,d,c,b,a} decoder.
module hex_to_7seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Standard hex glyphs, lowercase b and d so they differ from 8 and 0.
  always_comb begin
    seg = SEG_OFF;
    unique case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller. Each refresh tick blanks the
// display for BLANK_CYCLES clocks (ghosting guard) and then lights the next
// digit. Display data is snapshotted once per frame so a frame never mixes
// old and new values. Every output comes straight from a register.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic           clk,
  input  logic           reset,
  seg_scan_ctrl_if.slave bus
);

  localparam int unsigned       IDX_W     = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLANK_CYCLES - 1);

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [BCNT_W-1:0]       bcnt, bcnt_nxt;
  logic                    snap_load;
  logic                    frame_nxt;

  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp_en;
  logic [NUM_DIGITS-1:0]   snap_blank;

  logic [3:0]              nib;
  logic [6:0]              dec_seg;

  logic [NUM_DIGITS-1:0]   anode_nxt;
  logic [6:0]              seg_nxt;
  logic                    dp_nxt;

  logic [NUM_DIGITS-1:0]   anode_p1;
  logic [6:0]              seg_p1;
  logic                    dp_p1;
  logic                    frame_done_p1;

  assign nib = snap_digits[{idx, 2'b00} +: 4];

  hex_to_7seg u_dec (
    .hex (nib),
    .seg (dec_seg)
  );

  // Next-state, scan index, blanking count and display drive for this state.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    bcnt_nxt  = bcnt;
    snap_load = 1'b0;
    frame_nxt = 1'b0;
    anode_nxt = '1;
    seg_nxt   = SEG_OFF;
    dp_nxt    = 1'b1;

    unique case (state)
      ST_WAIT: begin
        if (bus.tick) begin
          state_nxt = ST_BLANK;
          idx_nxt   = '0;
          bcnt_nxt  = '0;
          snap_load = 1'b1;
        end
      end
      ST_BLANK: begin
        // Ticks are deliberately ignored here: a too-fast divider just
        // drops advances instead of skipping digits.
        if (bcnt == BCNT_LAST) begin
          state_nxt = ST_SHOW;
          bcnt_nxt  = '0;
        end else begin
          bcnt_nxt = bcnt + 8'd1;
        end
      end
      ST_SHOW: begin
        anode_nxt = ~(NUM_DIGITS'(1) << idx);
        seg_nxt   = snap_blank[idx] ? SEG_OFF : dec_seg;
        dp_nxt    = ~snap_dp_en[idx];
        if (bus.tick) begin
          state_nxt = ST_BLANK;
          bcnt_nxt  = '0;
          if (idx == IDX_LAST) begin
            idx_nxt   = '0;
            snap_load = 1'b1;
            frame_nxt = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_WAIT;
        idx_nxt   = '0;
        bcnt_nxt  = '0;
      end
    endcase
  end

  // Scan state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_WAIT;
    else        state <= state_nxt;
  end

  // Scan index, blanking counter and per-frame snapshot of display data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx         <= '0;
      bcnt        <= '0;
      snap_digits <= '0;
      snap_dp_en  <= '0;
      snap_blank  <= '0;
    end else begin
      idx  <= idx_nxt;
      bcnt <= bcnt_nxt;
      if (snap_load) begin
        snap_digits <= bus.digits;
        snap_dp_en  <= bus.dp_en;
        snap_blank  <= bus.blank;
      end
    end
  end

  // Stage p1: registered display outputs, one clock behind the scan state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anode_p1      <= '1;
      seg_p1        <= SEG_OFF;
      dp_p1         <= 1'b1;
      frame_done_p1 <= 1'b0;
    end else begin
      anode_p1      <= anode_nxt;
      seg_p1        <= seg_nxt;
      dp_p1         <= dp_nxt;
      frame_done_p1 <= frame_nxt;
    end
  end

  assign bus.anode      = anode_p1;
  assign bus.seg        = seg_p1;
  assign bus.dp         = dp_p1;
  assign bus.frame_done = frame_done_p1;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed digits, range 2..8.
REQ-002 Parameter BLANK_CYCLES, default 4: all-off clocks inserted before each digit is lit, range 1..255.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tick  input  1  single-cycle digit-advance strobe from the refresh-rate divider.
REQ-006 digits  input  4*NUM_DIGITS  hex value per digit; digit i at bits [4i+3:4i].
REQ-007 dp_en  input  NUM_DIGITS  decimal-point enable per digit, active-high.
REQ-008 blank  input  NUM_DIGITS  per-digit blank request, active-high.
REQ-009 anode  output  NUM_DIGITS  digit enables, active-low, one-cold or all-high.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  decimal point, active-low.
REQ-012 frame_done  output  1  one-cycle pulse when scan index wraps to 0.

Function
REQ-013 States: WAIT (post-reset, dark), BLANK (all digits off), SHOW (one digit lit).
REQ-014 WAIT: tick -> BLANK, idx = 0, snapshot loaded; no tick -> stay.
REQ-015 SHOW: tick -> BLANK, idx = (idx+1) mod NUM_DIGITS; no tick -> stay, outputs held.
REQ-016 BLANK: counts BLANK_CYCLES clocks from entry, then -> SHOW; tick during BLANK ignored (no idx change).
REQ-017 Snapshot register latches digits, dp_en, blank on every transition into BLANK with new idx = 0; displayed data changes only at frame start (no tearing).
REQ-018 frame_done pulses exactly one cycle, coincident with the snapshot load (the cycle after the wrapping tick is sampled); not asserted on the WAIT -> BLANK transition.
REQ-019 In SHOW: anode[idx] = 0, all other bits 1; seg = decode(snapshot nibble idx), or 7'h7F if snapshot blank[idx]; dp = ~snapshot dp_en[idx].
REQ-020 In WAIT and BLANK: anode = all 1s, seg = 7'h7F, dp = 1.
REQ-021 All outputs registered; no combinational path from any input to any output.
REQ-022 Latency: anode goes active exactly BLANK_CYCLES+1 clock edges after the edge that samples tick.
REQ-023 Decode standard hex, active-low: 0 -> 7'h40, 1 -> 7'h79, 2 -> 7'h24, 8 -> 7'h00, A -> 7'h08, F -> 7'h0E; all 16 codes defined.
REQ-024 idx width = ceil(log2(NUM_DIGITS)); wrap from NUM_DIGITS-1 to 0 for non-power-of-two counts; idx never exceeds NUM_DIGITS-1.
REQ-025 Blank counter width 8 bits; counts 0..BLANK_CYCLES-1, never wraps.
REQ-026 Tick period shorter than BLANK_CYCLES+1 is out of range; required behaviour is REQ-016 (ticks dropped, no corruption).

Reset
REQ-027 reset low: state = WAIT, idx = 0, blank counter = 0, snapshot = 0, anode = all 1s, seg = 7'h7F, dp = 1, frame_done = 0, immediately and independent of clk.
REQ-028 reset asserted mid-SHOW or mid-BLANK forces REQ-027 values; after release the block waits for a tick in WAIT.

Structure
REQ-029 Shared include holds state encodings, SEG_OFF = 7'h7F, and default NUM_DIGITS / BLANK_CYCLES.
REQ-030 One sub-module, hex_to_7seg (4-bit in, 7-bit active-low out, purely combinational), instantiated once on the muxed snapshot nibble.

Verification
REQ-031 Reset, no tick for 1000 clocks -> anode = 8'hFF, seg = 7'h7F, dp = 1, frame_done = 0 throughout.
REQ-032 digits = 32'h76543210, ticks every 20 clocks -> anode steps FE, FD, FB ... 7F, FE; seg shows 7'h40 then 7'h79 ...; anode active 5 clocks after each tick; frame_done once per 8 ticks.
REQ-033 Change digits to 32'hFFFFFFFF while idx = 3 -> digits 4..7 still show old values; 7'h0E appears only from idx 0 onward.
REQ-034 blank = 8'h04, dp_en = 8'h01 -> digit 2 lit with seg = 7'h7F; digit 0 has dp = 0; all others dp = 1.
REQ-035 Two ticks 2 clocks apart -> second tick ignored, idx advances by one only.
REQ-036 NUM_DIGITS = 6, reset pulsed low in SHOW at idx 5 -> outputs dark immediately; after wrap, idx sequence 0..5 then 0, never 6 or 7.
